// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor table controller.
package bp_pkg;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = 2'b01;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    LK_RD  = 2'd2,
    UPD_WR = 2'd3
  } bp_state_t;

  // Two-bit saturating counter step: taken counts up to 3, not taken down to 0.
  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic            taken);
    logic [CNT_W-1:0] res;
    if (taken) begin
      res = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end else begin
      res = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved branches until the table is free.
module bp_upd_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full      = (count_q == FILL_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next storage, pointer and occupancy values; pointers wrap because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FILL_W'(1);
      2'b01:   count_d = count_q - FILL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; a reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while empty so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Arbiter for the single-ported gshare counter table: init sweep, fetch lookups,
// queued read-modify-write training updates and the global history register.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_pc,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_index,
  input  logic             resolve_taken,
  output logic             resolve_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [CNT_W-1:0] tbl_wdata,
  input  logic [CNT_W-1:0] tbl_rdata,
  output logic [IDX_W-1:0] ghr,
  output logic             init_done
);

  // Queue entry; declared here because the index width follows IDX_W.
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             taken;
  } upd_entry_t;

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             init_done_q, init_done_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] lk_idx_q, lk_idx_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_taken_q, upd_taken_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_index_q, pred_index_d;

  logic             q_push, q_pop, q_full, q_empty;
  upd_entry_t       q_in, q_head;
  logic             start_upd;
  logic             lookup_ready_c, resolve_ready_c;
  logic             tbl_en_c, tbl_we_c;
  logic [IDX_W-1:0] tbl_addr_c;
  logic [CNT_W-1:0] tbl_wdata_c;

  assign q_in.index = resolve_index;
  assign q_in.taken = resolve_taken;

  bp_upd_fifo #(
    .DATA_W ($bits(upd_entry_t)),
    .DEPTH  (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Next-state, arbitration, table strobes and history update.
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    init_done_d     = init_done_q;
    ghr_d           = ghr_q;
    lk_idx_d        = lk_idx_q;
    upd_idx_d       = upd_idx_q;
    upd_taken_d     = upd_taken_q;
    pred_valid_d    = 1'b0;
    pred_taken_d    = pred_taken_q;
    pred_index_d    = pred_index_q;
    tbl_en_c        = 1'b0;
    tbl_we_c        = 1'b0;
    tbl_addr_c      = '0;
    tbl_wdata_c     = '0;
    q_pop           = 1'b0;
    start_upd       = 1'b0;
    lookup_ready_c  = (state_q == IDLE) && init_done_q && !q_full;
    resolve_ready_c = init_done_q && !q_full;
    q_push          = resolve_valid && resolve_ready_c && !reset;

    if (q_push) begin
      ghr_d = {ghr_q[IDX_W-2:0], resolve_taken};
    end

    case (state_q)
      INIT: begin
        tbl_en_c    = 1'b1;
        tbl_we_c    = 1'b1;
        tbl_addr_c  = sweep_q;
        tbl_wdata_c = CNT_INIT;
        sweep_d     = sweep_q + IDX_W'(1);
        if (sweep_q == '1) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (q_full) begin
          start_upd = 1'b1;
        end else if (lookup_valid) begin
          tbl_en_c   = 1'b1;
          tbl_addr_c = lookup_pc ^ ghr_q;
          lk_idx_d   = lookup_pc ^ ghr_q;
          state_d    = LK_RD;
        end else if (!q_empty) begin
          start_upd = 1'b1;
        end
        if (start_upd) begin
          q_pop       = 1'b1;
          tbl_en_c    = 1'b1;
          tbl_addr_c  = q_head.index;
          upd_idx_d   = q_head.index;
          upd_taken_d = q_head.taken;
          state_d     = UPD_WR;
        end
      end
      LK_RD: begin
        pred_valid_d = 1'b1;
        pred_taken_d = tbl_rdata[1];
        pred_index_d = lk_idx_q;
        state_d      = IDLE;
      end
      UPD_WR: begin
        tbl_en_c    = 1'b1;
        tbl_we_c    = 1'b1;
        tbl_addr_c  = upd_idx_q;
        tbl_wdata_c = sat_update(tbl_rdata, upd_taken_q);
        state_d     = IDLE;
      end
      default: begin
        state_d = INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Controller registers; reset drops any in-flight lookup or update and restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      ghr_q        <= '0;
      lk_idx_q     <= '0;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      init_done_q  <= init_done_d;
      ghr_q        <= ghr_d;
      lk_idx_q     <= lk_idx_d;
      upd_idx_q    <= upd_idx_d;
      upd_taken_q  <= upd_taken_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign lookup_ready  = lookup_ready_c && !reset;
  assign resolve_ready = resolve_ready_c && !reset;
  assign tbl_en        = tbl_en_c && !reset;
  assign tbl_we        = tbl_we_c && !reset;
  assign tbl_addr      = tbl_addr_c;
  assign tbl_wdata     = tbl_wdata_c;
  assign pred_valid    = pred_valid_q && !reset;
  assign pred_taken    = pred_taken_q && !reset;
  assign pred_index    = reset ? '0 : pred_index_q;
  assign init_done     = init_done_q && !reset;
  assign ghr           = ghr_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl with a behavioural single-port counter table.
module tb_bp_table_ctrl;

  logic       clk;
  logic       reset;
  logic       lookup_valid;
  logic [5:0] lookup_pc;
  logic       lookup_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic [5:0] pred_index;
  logic       resolve_valid;
  logic [5:0] resolve_index;
  logic       resolve_taken;
  logic       resolve_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [5:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata;
  logic [5:0] ghr;
  logic       init_done;

  logic [1:0] mem [64];
  logic       rst_req;
  int         checks;
  int         errors;

  bp_table_ctrl #(.IDX_W(6), .QDEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_ready  (lookup_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_index    (pred_index),
    .resolve_valid (resolve_valid),
    .resolve_index (resolve_index),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .tbl_en        (tbl_en),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .tbl_rdata     (tbl_rdata),
    .ghr           (ghr),
    .init_done     (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port table: writes land at the edge, read data appears the cycle after.
  initial tbl_rdata = 2'b00;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic lv, input logic [5:0] pc,
                               input logic rv, input logic [5:0] ri, input logic rt);
    @(negedge clk);
    reset         = rst_req;
    lookup_valid  = lv;
    lookup_pc     = pc;
    resolve_valid = rv;
    resolve_index = ri;
    resolve_taken = rt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated resolution: enqueue, then the read and the saturated write-back.
  task automatic updateStep(input string tag, input logic [5:0] idx, input logic tk,
                            input logic [1:0] wexp);
    applyStimulus(1'b0, 6'h00, 1'b1, idx, tk);
    checkOutput($sformatf("%s_rdy", tag), {resolve_ready, tbl_en}, 2'b10);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput($sformatf("%s_rd", tag), {tbl_en, tbl_we, tbl_addr}, {1'b1, 1'b0, idx});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput($sformatf("%s_wr", tag), {tbl_en, tbl_we, tbl_addr, tbl_wdata},
                {1'b1, 1'b1, idx, wexp});
  endtask

  // Full 64-entry sweep starting at the current cycle, ending in the first IDLE cycle.
  task automatic sweepCheck(input string tag);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
      checkOutput($sformatf("%s_addr", tag), {26'd0, tbl_addr}, i);
      checkOutput($sformatf("%s_ctl", tag),
                  {tbl_en, tbl_we, tbl_wdata, init_done, lookup_ready, resolve_ready},
                  7'b1101000);
    end
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput($sformatf("%s_done", tag), {init_done, lookup_ready, resolve_ready, tbl_en},
                4'b1110);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_req       = 1'b1;
    reset         = 1'b1;
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    resolve_valid = 1'b0;
    resolve_index = '0;
    resolve_taken = 1'b0;

    // Reset state
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("rst_outs", {pred_valid, pred_taken, pred_index, lookup_ready, resolve_ready,
                             init_done, tbl_en, tbl_we}, 13'd0);
    checkOutput("rst_ghr", {26'd0, ghr}, 32'd0);

    // Init sweep
    rst_req = 1'b0;
    sweepCheck("init");

    // Basic lookup, ghr = 0
    applyStimulus(1'b1, 6'h05, 1'b0, 6'h00, 1'b0);
    checkOutput("lk_acc", {lookup_ready, tbl_en, tbl_we, tbl_addr}, {3'b110, 6'h05});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("lk_rd", {tbl_en, lookup_ready, pred_valid}, 3'b000);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("lk_pred", {pred_valid, pred_taken, pred_index}, {2'b10, 6'h05});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("lk_pulse", {31'd0, pred_valid}, 32'd0);

    // Training: two taken resolves on 05, second enqueued while the first dequeues
    applyStimulus(1'b0, 6'h00, 1'b1, 6'h05, 1'b1);
    checkOutput("tr_push1", {resolve_ready, tbl_en}, 2'b10);
    applyStimulus(1'b0, 6'h00, 1'b1, 6'h05, 1'b1);
    checkOutput("tr_rd1", {tbl_en, tbl_we, tbl_addr, resolve_ready}, {2'b10, 6'h05, 1'b1});
    checkOutput("tr_ghr1", {26'd0, ghr}, 32'h01);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("tr_wr1", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, 6'h05, 2'b10});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("tr_rd2", {tbl_en, tbl_we, tbl_addr}, {2'b10, 6'h05});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("tr_wr2", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, 6'h05, 2'b11});
    applyStimulus(1'b1, 6'h06, 1'b0, 6'h00, 1'b0);
    checkOutput("tr_ghr2", {26'd0, ghr}, 32'h03);
    checkOutput("tr_lk", {lookup_ready, tbl_en, tbl_we, tbl_addr}, {3'b110, 6'h05});
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("tr_pred", {pred_valid, pred_taken, pred_index}, {2'b11, 6'h05});

    // Saturation on 0A
    updateStep("sat_t1", 6'h0A, 1'b1, 2'b10);
    updateStep("sat_t2", 6'h0A, 1'b1, 2'b11);
    updateStep("sat_t3", 6'h0A, 1'b1, 2'b11);
    updateStep("sat_n1", 6'h0A, 1'b0, 2'b10);
    updateStep("sat_n2", 6'h0A, 1'b0, 2'b01);
    updateStep("sat_n3", 6'h0A, 1'b0, 2'b00);
    updateStep("sat_n4", 6'h0A, 1'b0, 2'b00);

    // Queue full and priority, ghr = 30
    applyStimulus(1'b1, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("qf_ghr0", {26'd0, ghr}, 32'h30);
    checkOutput("qf_lk0", {lookup_ready, tbl_en, tbl_addr}, {2'b11, 6'h30});
    applyStimulus(1'b1, 6'h00, 1'b1, 6'h01, 1'b1);
    checkOutput("qf_q1", {lookup_ready, resolve_ready, tbl_en}, 3'b010);
    applyStimulus(1'b1, 6'h00, 1'b1, 6'h02, 1'b0);
    checkOutput("qf_pred0", {pred_valid, pred_taken, pred_index}, {2'b10, 6'h30});
    checkOutput("qf_lk1", {lookup_ready, resolve_ready, tbl_en, tbl_we, tbl_addr},
                {4'b1110, 6'h21});
    applyStimulus(1'b1, 6'h00, 1'b1, 6'h03, 1'b1);
    checkOutput("qf_q3", {resolve_ready, tbl_en}, 2'b10);
    applyStimulus(1'b1, 6'h00, 1'b1, 6'h04, 1'b1);
    checkOutput("qf_pred1", {pred_valid, pred_taken, pred_index}, {2'b10, 6'h21});
    checkOutput("qf_lk2", {lookup_ready, resolve_ready, tbl_en, tbl_we, tbl_addr},
                {4'b1110, 6'h05});
    applyStimulus(1'b1, 6'h00, 1'b1, 6'h07, 1'b1);
    checkOutput("qf_full_rdy", {31'd0, resolve_ready}, 32'd0);
    checkOutput("qf_ghr_hold", {26'd0, ghr}, 32'h0B);
    applyStimulus(1'b1, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("qf_ghr_after", {26'd0, ghr}, 32'h0B);
    checkOutput("qf_prio", {lookup_ready, resolve_ready, tbl_en, tbl_we, tbl_addr},
                {4'b0010, 6'h01});
    checkOutput("qf_pred2", {pred_valid, pred_taken, pred_index}, {2'b11, 6'h05});

    // Reset mid-update
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("mr_upd_wr", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, 6'h01, 2'b10});
    rst_req = 1'b1;
    reset   = 1'b1;
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("mr_outs", {tbl_en, tbl_we, pred_valid, resolve_ready, lookup_ready, init_done},
                6'd0);
    checkOutput("mr_ghr", {26'd0, ghr}, 32'd0);
    rst_req = 1'b0;
    sweepCheck("reinit");
    checkOutput("mr_q_empty", {pred_valid, ghr, tbl_en}, 8'd0);
    applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    checkOutput("mr_idle", {pred_valid, tbl_en, resolve_ready}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Controller/arbiter for the branch predictor's single-ported 2-bit counter table, in gshare style.
- Shares the table between two requesters:
  - fetch-stage lookups, indexed by pc ^ ghr;
  - execute-stage resolution updates, buffered in a small queue and applied as read-modify-write.
- Owns the global history register (ghr).
- Sequences a post-reset initialisation sweep of the table.

Parameters:
- IDX_W, 6, table index width; table holds 2^IDX_W entries.
- QDEPTH, 4, resolution queue depth (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- lookup_valid  in  1  fetch requests a prediction.
- lookup_pc  in  IDX_W  low PC bits of the fetched branch.
- lookup_ready  out  1  lookup accepted this cycle when lookup_valid is also high.
- pred_valid  out  1  one-cycle pulse; prediction result valid.
- pred_taken  out  1  counter MSB of the looked-up entry.
- pred_index  out  IDX_W  table index used for the lookup; travels with the branch down the pipeline.
- resolve_valid  in  1  branch resolved in execute.
- resolve_index  in  IDX_W  pred_index that was carried with the branch.
- resolve_taken  in  1  actual branch outcome.
- resolve_ready  out  1  queue can accept a resolution.
- tbl_en  out  1  table access strobe.
- tbl_we  out  1  write enable (valid while tbl_en is high).
- tbl_addr  out  IDX_W  table address.
- tbl_wdata  out  2  counter write data.
- tbl_rdata  in  2  counter read data, valid the cycle after a read.
- ghr  out  IDX_W  global history (debug/observability).
- init_done  out  1  high once the init sweep has finished.

Behaviour:
- Reset (synchronous):
  - State goes to INIT with sweep address 0.
  - Queue is flushed; ghr = 0.
  - Outputs are 0: pred_valid, pred_taken, pred_index, lookup_ready, resolve_ready, init_done, tbl_en, tbl_we.
  - Reset asserted mid-operation behaves identically: any in-flight lookup or update is dropped and no pred_valid is produced.
- INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=sweep, tbl_wdata=2'b01 (weakly not taken).
  - After address 2^IDX_W-1 is written, go to IDLE and set init_done=1 (sticky until reset).
  - lookup_ready=0 and resolve_ready=0 throughout INIT.
- Arbitration in IDLE, evaluated in priority order:
  1. Queue full: start an update.
  2. Otherwise, lookup_valid high: start a lookup.
  3. Otherwise, queue non-empty: start an update.
  4. Otherwise: no table access (tbl_en=0).
- lookup_ready = (state==IDLE) && init_done && !q_full. The handshake is combinational; lookup_valid must not depend on lookup_ready.
- Lookup, accepted in cycle N:
  - Cycle N: tbl_en=1, tbl_we=0, tbl_addr = lookup_pc ^ ghr. The index is latched.
  - Cycle N+1 (state LK_RD): tbl_rdata is captured and the FSM returns to IDLE.
  - Cycle N+2: pred_valid=1 for one cycle, with pred_taken = captured rdata[1] and pred_index = latched index.
  - Throughput: one lookup per 2 cycles.
- Update, dequeued in cycle M:
  - Cycle M: read tbl_addr = entry index.
  - Cycle M+1 (state UPD_WR): tbl_en=1, tbl_we=1, same address, tbl_wdata = sat(tbl_rdata, taken).
  - Cycle M+2: back to IDLE.
  - The entry is popped at cycle M.
- Saturation: taken gives min(3, c+1); not taken gives max(0, c-1). Counters are 2-bit unsigned.
- Queue:
  - resolve_ready = init_done && !q_full, using the occupancy at the start of the cycle.
  - Enqueue and dequeue in the same cycle are allowed; occupancy is unchanged.
  - Occupancy is tracked with a separate count register; pointers wrap modulo QDEPTH.
- ghr:
  - On each accepted resolution: ghr <= {ghr[IDX_W-2:0], resolve_taken}.
  - Non-speculative; unchanged when resolve_ready=0.
  - A lookup accepted in the same cycle uses the pre-shift ghr.
- Hazards: no forwarding from queued updates to lookups. A lookup that hits an entry with a pending update reads the stale counter; this is architecturally acceptable.
- FSM states: INIT, IDLE, LK_RD, UPD_WR. No other states; illegal encodings go to INIT.

Decomposition:
- Shared package bp_pkg:
  - CNT_W=2;
  - CNT_INIT=2'b01;
  - bp_state_t enum (INIT, IDLE, LK_RD, UPD_WR);
  - sat_update function;
  - queue entry typedef {index, taken}.
- One sub-module, bp_upd_fifo: parameterised synchronous FIFO providing full, empty, push, pop and head data. The FSM, arbitration and ghr stay in bp_table_ctrl.

Test Plan:
- INIT sweep: release reset -> 64 consecutive writes, addr 0..63, wdata 01. init_done rises the cycle after addr 63. lookup_ready and resolve_ready stay 0 until then.
- Basic lookup: ghr=0, lookup pc=6'h05 -> read addr 05. pred_valid at N+2 with pred_taken=0, pred_index=05.
- History and training: two resolves (idx 05, taken), no lookups -> writes 05<=10 then 05<=11; ghr=6'b000011. Then lookup pc=6'h06 -> addr 05, pred_taken=1, pred_index=05.
- Saturation on idx 0A:
  - Three taken updates -> writes 10, 11, 11.
  - Then four not-taken updates -> writes 10, 01, 00, 00.
- Queue full / priority: hold lookup_valid=1 and push 4 resolves while a lookup is busy.
  - The 5th resolve sees resolve_ready=0 and ghr does not shift.
  - The next IDLE cycle selects an update over the pending lookup, with lookup_ready=0 in that cycle.
- Reset mid-update: assert reset in UPD_WR -> next cycle tbl_en=0, queue empty, ghr=0, no pred_valid. After release, INIT restarts at addr 0.
